// File: rtl/seq_alu.sv
// Handshaked W-bit ALU: single-cycle logic/add/shift ops plus iterative
// shift-add multiply and restoring divide, with a full flag set.
module seq_alu #(
  parameter  int W     = 16,
  localparam int CNT_W = $clog2(W) + 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   opcode,
  input  logic         Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Y,
  output logic [W-1:0] Y_HI,
  output logic         Cout,
  output logic         Z,
  output logic         N,
  output logic         V,
  output logic         DZ
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd8, OP_NOR = 4'd9,  OP_XNOR = 4'd10, OP_SHL = 4'd11;
  localparam logic [3:0] OP_SHR = 4'd12, OP_ROR = 4'd13, OP_ROL = 4'd14, OP_ADC = 4'd15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             is_div_q, is_div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     y_q, y_d, yhi_q, yhi_d;
  logic             cout_q, cout_d, z_q, z_d, n_q, n_d, v_q, v_d, dz_q, dz_d;

  logic [W-1:0]   f_y;
  logic           f_cout, f_v;
  logic [W:0]     add_w, sub_w;
  logic [W:0]     mul_sum, div_r, div_rem;
  logic           div_ge;
  logic [2*W-1:0] iter_acc;

  // Single-cycle datapath, evaluated straight from the inputs in the accept cycle
  always_comb begin
    add_w  = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, (opcode == OP_ADC) & Cin};
    sub_w  = {1'b0, A} - {1'b0, B};
    f_y    = '0;
    f_cout = 1'b0;
    f_v    = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        f_y    = add_w[W-1:0];
        f_cout = add_w[W];
        f_v    = (A[W-1] == B[W-1]) && (add_w[W-1] != A[W-1]);
      end
      OP_SUB: begin
        f_y    = sub_w[W-1:0];
        f_cout = sub_w[W];
        f_v    = (A[W-1] != B[W-1]) && (sub_w[W-1] != A[W-1]);
      end
      OP_AND:  f_y = A & B;
      OP_OR:   f_y = A | B;
      OP_XOR:  f_y = A ^ B;
      OP_NOT:  f_y = ~A;
      OP_NAND: f_y = ~(A & B);
      OP_NOR:  f_y = ~(A | B);
      OP_XNOR: f_y = ~(A ^ B);
      OP_SHL: begin f_y = {A[W-2:0], Cin};    f_cout = A[W-1]; end
      OP_SHR: begin f_y = {Cin, A[W-1:1]};    f_cout = A[0];   end
      OP_ROR: begin f_y = {A[0], A[W-1:1]};   f_cout = A[0];   end
      OP_ROL: begin f_y = {A[W-2:0], A[W-1]}; f_cout = A[W-1]; end
      default: ;
    endcase
  end

  // One multiply or divide step. MUL: acc = {partial, multiplier}, shifted right.
  // DIV: acc = {remainder, dividend/quotient}, shifted left; B==0 naturally
  // yields quotient all ones and remainder A.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_r    = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge   = (div_r >= {1'b0, b_q});
    div_rem  = div_ge ? (div_r - {1'b0, b_q}) : div_r;
    iter_acc = is_div_q ? {div_rem[W-1:0], acc_q[W-2:0], div_ge}
                        : {mul_sum, acc_q[W-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    y_d      = y_q;
    yhi_d    = yhi_q;
    cout_d   = cout_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = A;
          b_d   = B;
          cnt_d = '0;
          if (opcode == OP_MUL || opcode == OP_DIV) begin
            is_div_d = (opcode == OP_DIV);
            acc_d    = {{W{1'b0}}, (opcode == OP_DIV) ? A : B};
            state_d  = BUSY;
          end else begin
            y_d     = f_y;
            yhi_d   = '0;
            cout_d  = f_cout;
            z_d     = (f_y == '0);
            n_d     = f_y[W-1];
            v_d     = f_v;
            dz_d    = 1'b0;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        acc_d = iter_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W-1)) begin
          y_d     = iter_acc[W-1:0];
          yhi_d   = iter_acc[2*W-1:W];
          cout_d  = !is_div_q && (iter_acc[2*W-1:W] != '0);
          z_d     = (iter_acc[W-1:0] == '0);
          n_d     = iter_acc[W-1];
          v_d     = 1'b0;
          dz_d    = is_div_q && (b_q == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      yhi_q    <= '0;
      cout_q   <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      yhi_q    <= yhi_d;
      cout_q   <= cout_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      dz_q     <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Y         = y_q;
  assign Y_HI      = yhi_q;
  assign Cout      = cout_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;
  assign DZ        = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, randomized ops against an
// arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_seq_alu;
  localparam int W = 16;

  logic         CLK = 1'b0, RST_N = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0, Cin = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0]   opcode = '0;
  logic         in_ready, out_valid, Cout, Z, N, V, DZ;
  logic [W-1:0] Y, Y_HI;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  seq_alu #(.W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .Cin(Cin), .out_valid(out_valid),
    .out_ready(out_ready), .Y(Y), .Y_HI(Y_HI), .Cout(Cout), .Z(Z), .N(N),
    .V(V), .DZ(DZ)
  );

  typedef struct {
    logic [15:0] y, yhi;
    logic        cout, z, n, v, dz;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] y, yhi;
    logic        cout, z, n, v, dz;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic cmp_res(input string tag, input res_t got, input res_t exp);
    chk({tag, ".Y"},    got.y,    exp.y);
    chk({tag, ".Y_HI"}, got.yhi,  exp.yhi);
    chk({tag, ".Cout"}, got.cout, exp.cout);
    chk({tag, ".Z"},    got.z,    exp.z);
    chk({tag, ".N"},    got.n,    exp.n);
    chk({tag, ".V"},    got.v,    exp.v);
    chk({tag, ".DZ"},   got.dz,   exp.dz);
  endtask

  // Reference computed with plain integer arithmetic
  function automatic res_t model(input logic [3:0] op, input logic [15:0] a, b, input logic cin);
    res_t   r;
    int     sa, sb, s, c;
    longint u;
    r  = '{default: '0};
    sa = $signed(a);
    sb = $signed(b);
    c  = (op == 4'd15 && cin) ? 1 : 0;
    case (op)
      4'd0, 4'd15: begin
        u = longint'(a) + longint'(b) + c;
        r.y = u[15:0];
        r.cout = (u >= 65536);
        s = sa + sb + c;
        r.v = (s > 32767) || (s < -32768);
      end
      4'd1: begin
        r.y = a - b;
        r.cout = (a < b);
        s = sa - sb;
        r.v = (s > 32767) || (s < -32768);
      end
      4'd2: begin
        u = longint'(a) * longint'(b);
        r.y = u[15:0];
        r.yhi = u[31:16];
        r.cout = (u >= 65536);
      end
      4'd3: begin
        if (b == 0) begin r.y = 16'hFFFF; r.yhi = a; r.dz = 1'b1; end
        else begin r.y = a / b; r.yhi = a % b; end
      end
      4'd4:  r.y = a & b;
      4'd5:  r.y = a | b;
      4'd6:  r.y = a ^ b;
      4'd7:  r.y = ~a;
      4'd8:  r.y = ~(a & b);
      4'd9:  r.y = ~(a | b);
      4'd10: r.y = ~(a ^ b);
      4'd11: begin r.y = (a << 1) + (cin ? 16'd1 : 16'd0);          r.cout = (a >= 16'h8000); end
      4'd12: begin r.y = (a >> 1) + (cin ? 16'h8000 : 16'h0);      r.cout = (a % 2 == 1);    end
      4'd13: begin r.y = (a >> 1) + ((a % 2 == 1) ? 16'h8000 : 16'h0); r.cout = (a % 2 == 1); end
      4'd14: begin r.y = (a << 1) + ((a >= 16'h8000) ? 16'd1 : 16'd0); r.cout = (a >= 16'h8000); end
      default: ;
    endcase
    r.z = (r.y == 0);
    r.n = (r.y >= 16'h8000);
    return r;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, b, input logic cin,
                        output res_t r, output int lat);
    int guard = 0;
    bit busy_ok = 1'b1;
    while (!in_ready && guard < 50) begin @(posedge CLK); #1; guard++; end
    @(negedge CLK);
    opcode = op; A = a; B = b; Cin = cin; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); opcode = 4'($urandom); Cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge CLK); #1;
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    chk("in_ready_low_while_busy", busy_ok, 1);
    r.y = Y; r.yhi = Y_HI; r.cout = Cout; r.z = Z; r.n = N; r.v = V; r.dz = DZ;
    @(negedge CLK); out_ready = 1'b1;
    @(posedge CLK); #1; out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_after_handshake", in_ready, 1);
  endtask

  initial begin
    vec_t tv[15];
    res_t got, exp;
    int   lat, guard;
    bit   stale;

    tv[0]  = '{4'd0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tv[1]  = '{4'd0,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tv[2]  = '{4'd1,  16'h0003, 16'h0005, 1'b0, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tv[3]  = '{4'd2,  16'h1234, 16'h5678, 1'b0, 16'h0060, 16'h0626, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    tv[4]  = '{4'd3,  16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    tv[5]  = '{4'd3,  16'h00AB, 16'h0000, 1'b0, 16'hFFFF, 16'h00AB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 17};
    tv[6]  = '{4'd11, 16'h8001, 16'h0000, 1'b1, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tv[7]  = '{4'd13, 16'h0001, 16'h0000, 1'b0, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tv[8]  = '{4'd14, 16'h8000, 16'h0000, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tv[9]  = '{4'd12, 16'h0003, 16'h0000, 1'b1, 16'h8001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tv[10] = '{4'd4,  16'hFF00, 16'h0F0F, 1'b1, 16'h0F00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tv[11] = '{4'd7,  16'h0000, 16'h1234, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tv[12] = '{4'd15, 16'h0001, 16'h0001, 1'b1, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tv[13] = '{4'd1,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tv[14] = '{4'd10, 16'hAAAA, 16'hAAAA, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};

    #2 RST_N = 1'b0;
    #10;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    cmp_res("rst", '{Y, Y_HI, Cout, Z, N, V, DZ}, '{16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge CLK); RST_N = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].cin, got, lat);
      exp = '{tv[i].y, tv[i].yhi, tv[i].cout, tv[i].z, tv[i].n, tv[i].v, tv[i].dz};
      cmp_res($sformatf("vec%0d", i), got, exp);
      chk($sformatf("vec%0d.latency", i), lat, tv[i].lat);
    end

    for (int i = 0; i < 80; i++) begin
      logic [3:0]  op;
      logic [15:0] a, b;
      logic        cin;
      op  = 4'($urandom_range(0, 15));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      cin = 1'($urandom);
      run_op(op, a, b, cin, got, lat);
      cmp_res($sformatf("rnd%0d_op%0d", i, op), got, model(op, a, b, cin));
      chk($sformatf("rnd%0d.latency", i), lat, (op == 4'd2 || op == 4'd3) ? 17 : 1);
    end

    // Backpressure: result must hold while out_ready stays low
    @(negedge CLK);
    opcode = 4'd2; A = 16'h1234; B = 16'h5678; in_valid = 1'b1;
    @(posedge CLK); #1; in_valid = 1'b0; A = 16'hDEAD; B = 16'hBEEF;
    guard = 0;
    while (!out_valid && guard < 40) begin @(posedge CLK); #1; guard++; end
    chk("bp.out_valid_seen", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      chk("bp.out_valid_held", out_valid, 1);
      chk("bp.in_ready_low", in_ready, 0);
      cmp_res("bp", '{Y, Y_HI, Cout, Z, N, V, DZ}, '{16'h0060, 16'h0626, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    @(negedge CLK); out_ready = 1'b1;
    @(posedge CLK); #1; out_ready = 1'b0;
    chk("bp.release", out_valid, 0);

    // Reset pulse in the middle of a second multiply
    @(negedge CLK);
    opcode = 4'd2; A = 16'h00FF; B = 16'h0101; in_valid = 1'b1;
    @(posedge CLK); #1; in_valid = 1'b0;
    repeat (8) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.out_valid", out_valid, 0);
    cmp_res("midrst", '{Y, Y_HI, Cout, Z, N, V, DZ}, '{16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge CLK); RST_N = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge CLK); #1;
      if (out_valid || !in_ready) stale = 1'b1;
    end
    chk("midrst.no_stale_result", stale, 0);

    run_op(4'd6, 16'h0F0F, 16'h00FF, 1'b0, got, lat);
    cmp_res("post_rst", got, model(4'd6, 16'h0F0F, 16'h00FF, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
